// File: rtl/dadda_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dadda_mult_arbiter (with leaf dadda_8)                          |
// | Brief    : round-robin share of one signed 8x8 multiplier among NREQ       |
// |            requesters; optional fixed-point output via MULT_ARB_FXP_EN.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module dadda_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] y
);
  logic [15:0] w_a_ext;
  logic [15:0] w_acc;

  assign w_a_ext = {{8{a[7]}}, a};

  // Rows 0..6 carry positive weight; the b[7] row carries weight -2^7.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) w_acc = w_acc + (w_a_ext << i);
    end
    if (b[7]) w_acc = w_acc - (w_a_ext << 7);
  end

  assign y = w_acc;
endmodule

module dadda_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int FRAC = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_y,
  output logic [7:0]        rsp_q,
  output logic              busy
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_op_id;
  logic [IDW-1:0]  r_res_id;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic [15:0]     r_res_y;
  logic [15:0]     w_y;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;
  logic            w_gnt_any;
  logic            w_arb_en;
  logic            w_take;

  // Scan offsets high to low so the smallest offset from r_rr_ptr wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (int'(r_rr_ptr) + k >= NREQ) w_idx = IDW'(int'(r_rr_ptr) + k - NREQ);
      else                            w_idx = IDW'(int'(r_rr_ptr) + k);
      if (req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  // Reset also masks the combinational grant so req_ready drops immediately.
  assign w_arb_en  = rst_n && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
  assign w_take    = w_arb_en && w_gnt_any;
  assign req_ready = w_take ? (NREQ'(1) << w_gnt_id) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = w_gnt_any ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  dadda_8 u_mult (
    .a (r_op_a),
    .b (r_op_b),
    .y (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_op_id  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res_id <= '0;
      r_res_y  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_op_a   <= req_a[w_gnt_id*8 +: 8];
        r_op_b   <= req_b[w_gnt_id*8 +: 8];
        r_op_id  <= w_gnt_id;
        r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
      end
      if (r_state == S_ISSUE) begin
        r_res_y  <= w_y;
        r_res_id <= r_op_id;
      end
    end
  end

`ifdef MULT_ARB_FXP_EN
  localparam logic signed [16:0] c_half = 17'sd1 <<< (FRAC - 1);

  logic signed [16:0] w_rnd;
  logic signed [16:0] w_shf;
  logic [7:0]         w_q;
  logic [7:0]         r_res_q;

  // 17 bits hold the product plus the rounding offset without overflow.
  assign w_rnd = $signed({w_y[15], w_y}) + c_half;
  assign w_shf = w_rnd >>> FRAC;
  assign w_q   = (w_shf > 17'sd127)  ? 8'h7F :
                 (w_shf < -17'sd128) ? 8'h80 : w_shf[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_res_q <= '0;
    else if (r_state == S_ISSUE) r_res_q <= w_q;
  end

  assign rsp_q = r_res_q;
`else
  assign rsp_q = 8'h00;
`endif

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_res_id;
  assign rsp_y     = r_res_y;
  assign busy      = (r_state != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_dadda_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dadda_mult_arbiter                                           |
// | Brief    : randomized scoreboard bench with a transaction-level model.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dadda_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int FRAC = 7;

  typedef struct {
    int id;
    int y;
    int q;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_y;
  logic [7:0]        rsp_q;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;

  exp_t            sb[$];
  logic [NREQ-1:0] pend = '0;
  logic [7:0]      oa[NREQ];
  logic [7:0]      ob[NREQ];
  logic [NREQ-1:0] acc_mask = '0;
  bit              mdl_rst = 1'b0;

  dadda_mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_q     (rsp_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Rounded-half-up fixed point value using floor division, clamped to int8.
  function automatic int fxp(int y);
`ifdef MULT_ARB_FXP_EN
    int t;
    int d;
    d = 1 << FRAC;
    t = y + d / 2;
    t = (t >= 0) ? t / d : -((-t + d - 1) / d);
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return t;
`else
    return 0;
`endif
  endfunction

  // Transaction model: one operation in flight, response visible two cycles after accept.
  int  cyc = 0;
  int  acc_cyc = 0;
  int  rr = 0;
  bit  inflight = 1'b0;
  always @(negedge clk) begin
    bit   visible;
    int   g;
    exp_t e;
    if (mdl_rst || !rst_n) begin
      sb.delete();
      rr       = 0;
      inflight = 1'b0;
      acc_mask = '0;
      mdl_rst  = 1'b0;
    end
    if (rst_n) begin
      visible = inflight && (cyc >= acc_cyc + 2);
      chk("busy", longint'(busy), longint'(inflight));
      chk("rsp_valid", longint'(rsp_valid), longint'(visible));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          chk("rsp_id", longint'(rsp_id), longint'(sb[0].id));
          chk("rsp_y", longint'($signed(rsp_y)), longint'(sb[0].y));
          chk("rsp_q", longint'($signed(rsp_q)), longint'(sb[0].q));
        end
      end
      if (visible && rsp_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        inflight = 1'b0;
      end
      g = -1;
      if (!inflight) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
        end
      end
      chk("req_ready", longint'(req_ready), (g < 0) ? 0 : longint'(1) << g);
      acc_mask = req_ready & req_valid;
      if (g >= 0) begin
        e.id = g;
        e.y  = int'($signed(req_a[g*8 +: 8])) * int'($signed(req_b[g*8 +: 8]));
        e.q  = fxp(e.y);
        sb.push_back(e);
        rr       = (g + 1) % NREQ;
        inflight = 1'b1;
        acc_cyc  = cyc;
      end
    end
    cyc++;
  end

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*8 +: 8] = oa[i];
      req_b[i*8 +: 8] = ob[i];
    end
  endtask

  task automatic post(int i, int a, int b);
    pend[i] = 1'b1;
    oa[i]   = 8'(a);
    ob[i]   = 8'(b);
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pend = pend & ~acc_mask;
    drive();
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while ((pend != 0 || busy || sb.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) chk("idle_timeout", n, 0);
  endtask

  function automatic int rand8();
    case ($urandom_range(0, 7))
      0:       return -128;
      1:       return 127;
      2:       return 0;
      3:       return -1;
      default: return int'($signed(8'($urandom)));
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_rsp_id", longint'(rsp_id), 0);
    chk("rst_rsp_y", longint'(rsp_y), 0);
    chk("rst_rsp_q", longint'(rsp_q), 0);
    chk("rst_busy", longint'(busy), 0);
    rst_n = 1'b1;

    // Fairness: all requesters refilled continuously with rsp_ready high.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) post(i, rand8(), rand8());
    repeat (12) begin
      step();
      for (int i = 0; i < NREQ; i++) if (!pend[i]) post(i, rand8(), rand8());
    end
    pend = '0;
    drive();
    wait_idle(40);

    // Single request and corner products.
    post(2, 5, -3);
    wait_idle(20);
    post(0, -128, -128); wait_idle(20);
    post(1, -128, 127);  wait_idle(20);
    post(3, 127, 127);   wait_idle(20);
    post(2, 0, -128);    wait_idle(20);
    post(0, 64, 64);     wait_idle(20);
    post(1, -1, 64);     wait_idle(20);

    // Backpressure with requester 1 pending.
    step();
    post(0, 3, 4);
    rsp_ready = 1'b0;
    repeat (3) step();
    post(1, 7, -9);
    repeat (5) step();
    rsp_ready = 1'b1;
    wait_idle(20);

    // Randomized traffic with random backpressure and withdrawals.
    repeat (600) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) post(i, rand8(), rand8());
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      drive();
    end
    rsp_ready = 1'b1;
    pend = '0;
    drive();
    wait_idle(40);

    // Reset pulse while a response is being held.
    rsp_ready = 1'b0;
    post(2, 11, 13);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_wait_timeout", longint'(rsp_valid), 1);
    post(3, 2, 2);
    post(1, -5, 6);
    #1;
    rst_n   = 1'b0;
    mdl_rst = 1'b1;
    #1;
    chk("pulse_rsp_valid", longint'(rsp_valid), 0);
    chk("pulse_req_ready", longint'(req_ready), 0);
    chk("pulse_rsp_y", longint'(rsp_y), 0);
    chk("pulse_rsp_id", longint'(rsp_id), 0);
    chk("pulse_rsp_q", longint'(rsp_q), 0);
    chk("pulse_busy", longint'(busy), 0);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    wait_idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/dadda_mult_arbiter.md
# dadda_mult_arbiter

Round-robin scheduler that shares one combinational `dadda_8` signed 8x8 multiplier among `NREQ` independent requesters. Each requester presents operands with a valid/ready handshake. The block grants one request at a time and latches the operands into registers that drive the multiplier. It returns the registered 16-bit signed product, tagged with the requester index, on a single valid/ready response channel. It sits between the multiply clients and the shared Dadda/Booth datapath.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester tag.
- `FRAC`, 7: fractional bits removed by the fixed-point output path, legal range 1..14.

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input NREQ: per-requester request strobe.
- `req_a` input NREQ*8: packed signed multiplicands; requester i uses bits [8i+7:8i].
- `req_b` input NREQ*8: packed signed multipliers, same packing as `req_a`.
- `req_ready` output NREQ: one-hot grant/accept; at most one bit is set.
- `rsp_valid` output 1: product available.
- `rsp_ready` input 1: consumer accepts the product.
- `rsp_id` output IDW: index of the requester that owns the product.
- `rsp_y` output 16: signed product A*B.
- `rsp_q` output 8: rounded and saturated fixed-point product; see Configuration.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - On the clock edge: latch `op_a`, `op_b` and `op_id=g`; set `rr_ptr=(g+1)%NREQ`; go to ISSUE.
  - If no `req_valid` bit is set, stay in IDLE.
- **ISSUE**
  - `op_a` and `op_b` drive `dadda_8`.
  - On the clock edge: capture its `y` into `res_y`, compute `res_q`, go to RESP.
  - `req_ready` is all zeros.
- **RESP**
  - `rsp_valid=1`; `rsp_y`, `rsp_q` and `rsp_id` are stable until the handshake completes.
  - If `rsp_ready=0`: hold; `req_ready` stays all zeros.
  - If `rsp_ready=1` and no `req_valid` bit is set: go to IDLE.
  - If `rsp_ready=1` and some `req_valid` bit is set: arbitrate exactly as in IDLE in the same cycle (grant, latch, pointer update) and go directly to ISSUE.
- Requester obligations:
  - A requester keeps `req_valid` asserted with stable operands until it sees its `req_ready` bit.
  - A requester may deassert `req_valid` before being granted; the block tolerates this.
  - The arbiter never grants a requester whose `req_valid` is low.
- Arithmetic:
  - Operands are two's complement.
  - `rsp_y` holds the exact product; the range -16256..16384 always fits in 16 bits.
- `rr_ptr` width is IDW. It wraps from NREQ-1 to 0 and never holds a value of NREQ or above.

## Timing
- Values after reset:
  - `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`, `rsp_q=0`, `busy=0`.
  - State is IDLE and `rr_ptr=0`.
- Reset mid-operation:
  - Asserting `rst_n` low in any state immediately forces the reset values.
  - The in-flight operation is discarded and no response is produced for it.
- Latency: accept in cycle T; `rsp_valid` rises in cycle T+2.
- Throughput:
  - With `rsp_ready` held high and requests continuously pending, one product completes every 2 cycles (accept in RESP → ISSUE → RESP).
  - From IDLE the first product appears after 2 cycles.
- Simultaneous events: a response handshake and a new grant in the same cycle are both legal and both take effect.
- Combinational path: `req_ready` depends on `req_valid`. No other output depends combinationally on any input.

## Configuration
- Macro: `MULT_ARB_FXP_EN`.
- Defined:
  - `res_q = sat8((res_y + (1 << (FRAC-1))) >>> FRAC)`, which rounds half up (toward +inf).
  - `sat8` clamps the result to [-128, 127].
  - `res_q` is registered together with `res_y` and presented on `rsp_q`.
- Undefined:
  - `rsp_q` is tied to 8'h00 and no rounding or saturation logic is synthesized.
  - `rsp_y` behaviour is identical in both builds.

## Test plan
- Single request:
  - Stimulus: requester 2 sends A=5, B=-3.
  - Response: `req_ready=4'b0100` in cycle T; `rsp_valid` at T+2 with `rsp_y=-15` (16'hFFF1) and `rsp_id=2`; with the macro, `rsp_q=0`.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold `req_valid`; `rsp_ready=1`.
  - Response: grant order 0,1,2,3,0.
  - Response: consecutive grants are 2 cycles apart.
  - Response: `rr_ptr` wraps to 0 after the grant to requester 3.
- Backpressure:
  - Stimulus: hold `rsp_ready=0` for 5 cycles while requester 1 is pending.
  - Response: `rsp_y`, `rsp_id` and `rsp_q` stay stable.
  - Response: `req_ready` stays 0 for the whole stall.
  - Response: requester 1 is granted in the cycle `rsp_ready` rises.
- Corner products:
  - Stimulus: -128*-128, -128*127, 127*127, 0*-128.
  - Response: `rsp_y` = 16384, -16256, 16129, 0 respectively.
- Fixed-point path (`MULT_ARB_FXP_EN`, `FRAC=7`):
  - Stimulus: 64*64, -128*-128, -128*127, -1*64.
  - Response: `rsp_q` = 32, 127 (saturated), -127, 0 respectively.
- Reset during RESP:
  - Stimulus: pulse `rst_n` low for a partial cycle while `rsp_valid=1`.
  - Response: outputs return to their reset values immediately.
  - Response: the first grant after reset goes to the lowest pending index.
